pong_match_ctrl: RTL
====================

# pong_match_ctrl

Match sequencer for the Pong game. It owns the game-level state machine (idle, serve, play, pause, point, game over) and gates the per-frame step of the ball/paddle physics datapath. It keeps the packed score and recentres the ball between points. It sits between the video timing generator, which supplies `frame_tick`, and the physics engine, which consumes `phys_en`, `ball_hold` and `serve_dir` and reports misses.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, default 60: number of frame ticks spent in SERVE before play; legal range 1..255.
- `POINT_FRAMES`, default 30: number of frame ticks spent in POINT after a miss; legal range 1..255.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `btn_start`  in  1  debounced, synchronous level.
- `btn_pause`  in  1  debounced, synchronous level.
- `miss_left`  in  1  one-cycle pulse: ball passed the opponent paddle (left). Player scores.
- `miss_right`  in  1  one-cycle pulse: ball passed the player paddle (right). Opponent scores.
- `phys_en`  out  1  one-cycle physics step strobe.
- `ball_hold`  out  1  level: physics must hold the ball at centre (320,240).
- `serve_dir`  out  1  serve direction: 1 = right/toward player, 0 = left.
- `score`  out  8  packed score {opponent[7:4], player[3:0]}.
- `state`  out  3  current state encoding.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  valid in OVER: 1 = player won, 0 = opponent won.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `score`=0, `serve_dir`=1, `phys_en`=0, `ball_hold`=1, `game_over`=0, `winner`=0. Frame counter = 0. Button edge registers = 0.
- Buttons are rising-edge detected internally: `start_rise = btn_start & ~start_q`, and likewise `pause_rise`.
- State encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- IDLE: `start_rise` → SERVE, with `score` cleared and `serve_dir`=1.
- SERVE: count `frame_tick`s. On the SERVE_FRAMES-th tick → PLAY.
- PLAY:
  - `miss_left` → player score +1, `serve_dir`←0, → POINT.
  - else `miss_right` → opponent score +1, `serve_dir`←1, → POINT.
  - else `pause_rise` → PAUSE.
  - Priority is `miss_left` > `miss_right` > `pause_rise`. When both misses arrive in the same cycle, only the player scores.
- PAUSE:
  - `pause_rise` → PLAY.
  - Misses and ticks are ignored.
  - The frame counter is not used here.
- POINT: count ticks. On the POINT_FRAMES-th tick:
  - → OVER if either nibble == WIN_SCORE, with `winner` = (player nibble == WIN_SCORE).
  - otherwise → SERVE.
- OVER: `start_rise` → SERVE, with `score` cleared and `serve_dir`=1.
- Score nibbles saturate at 15 and never wrap.
- `ball_hold` = 1 in IDLE, SERVE, POINT and OVER. It is 0 in PLAY and PAUSE; the ball freezes in PAUSE because `phys_en` is 0.
- Counter: 8 bits, cleared on every state transition. It increments only on `frame_tick` while in SERVE or POINT.

## Timing
- A state change takes effect at the clock edge that samples the triggering input. The new `state`, `ball_hold` and `score` are visible in the same cycle after that edge.
- `phys_en` is asserted in the cycle after a `frame_tick` is sampled while `state`==PLAY. Its width is exactly one cycle.
- If `frame_tick` and a miss are sampled in the same PLAY cycle, the transition to POINT still occurs and `phys_en` still pulses once.
- A `frame_tick` on the edge that enters SERVE or POINT is not counted. The exit happens on exactly the Nth tick sampled afterwards.
- A miss in PLAY updates `score` at the same edge that moves `state` to POINT. Latency is 1 clock.
- Reset mid-operation: outputs go to their reset values immediately on `rst_n` low, without waiting for a clock edge. Operation resumes from IDLE after release.
- A held button generates exactly one edge.

## Test plan
- Reset released, `btn_start` pulsed, SERVE_FRAMES=3, then 3 ticks → `state` goes 0→1→2 on the third tick, and `ball_hold` falls to 0. On the next tick `phys_en` pulses for 1 cycle.
- In PLAY, `miss_left` → `score`=0x01, `serve_dir`=0, `state`=4. After POINT_FRAMES ticks → `state`=1.
- In PLAY, `miss_left` and `miss_right` asserted in the same cycle → `score`=0x01 only.
- Opponent reaches WIN_SCORE=7 (`score`=0x73), then POINT expires → `state`=5, `game_over`=1, `winner`=0. Then `btn_start` → `score`=0x00, `state`=1.
- In PLAY, `btn_pause` rises → `state`=3. Ticks and misses in PAUSE cause no `phys_en` and no score change. A second pause edge → `state`=2.
- `rst_n` asserted mid-POINT, with no clock edge → all outputs are at their reset values immediately.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: game-level sequencer for Pong.
// Runs the idle/serve/play/pause/point/over state machine, keeps the packed
// score, gates the per-frame physics step and tells the physics engine when
// to hold the ball at centre and which way to serve.
//
// Handshake: there is no valid/ready flow here. frame_tick, miss_left and
// miss_right are single-cycle pulses sampled on the rising clock edge;
// btn_start/btn_pause are levels whose rising edge is the event. phys_en is a
// single-cycle strobe the physics engine consumes unconditionally.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       phys_en,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // Exit happens on the tick that finds the counter at N-1, i.e. the Nth tick.
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN_NIB    = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] ply_q, ply_d;
    logic [3:0] opp_q, opp_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       winner_q, winner_d;
    logic       phys_en_q, phys_en_d;
    logic       hold_q, hold_d;
    logic       over_q, over_d;
    logic       start_q, pause_q;
    logic       start_rise, pause_rise;

    assign start_rise = btn_start & ~start_q;
    assign pause_rise = btn_pause & ~pause_q;

    // State register plus every registered output and the button edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ply_q     <= 4'd0;
            opp_q     <= 4'd0;
            cnt_q     <= 8'd0;
            dir_q     <= 1'b1;
            winner_q  <= 1'b0;
            phys_en_q <= 1'b0;
            hold_q    <= 1'b1;
            over_q    <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ply_q     <= ply_d;
            opp_q     <= opp_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            phys_en_q <= phys_en_d;
            hold_q    <= hold_d;
            over_q    <= over_d;
            start_q   <= btn_start;
            pause_q   <= btn_pause;
        end
    end

    // Next-state, score, counter and output decode.
    always_comb begin
        state_d  = state_q;
        ply_d    = ply_q;
        opp_d    = opp_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        winner_d = winner_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_SERVE;
                    ply_d   = 4'd0;
                    opp_d   = 4'd0;
                    dir_d   = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) state_d = S_PLAY;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            S_PLAY: begin
                // Left miss wins a simultaneous double miss: only the player scores.
                if (miss_left) begin
                    ply_d   = (ply_q == 4'hF) ? ply_q : ply_q + 4'd1;
                    dir_d   = 1'b0;
                    state_d = S_POINT;
                end else if (miss_right) begin
                    opp_d   = (opp_q == 4'hF) ? opp_q : opp_q + 4'd1;
                    dir_d   = 1'b1;
                    state_d = S_POINT;
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_rise) state_d = S_PLAY;
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (ply_q == WIN_NIB || opp_q == WIN_NIB) begin
                            state_d  = S_OVER;
                            winner_d = (ply_q == WIN_NIB);
                        end else begin
                            state_d = S_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d  = S_SERVE;
                    ply_d    = 4'd0;
                    opp_d    = 4'd0;
                    dir_d    = 1'b1;
                    winner_d = 1'b0;
                end
            end
            default: begin
                // Codes 6 and 7 are unreachable; recover to a known state.
                state_d = S_IDLE;
            end
        endcase

        // Every transition starts the next phase with a fresh frame count.
        if (state_d != state_q) cnt_d = 8'd0;

        phys_en_d = frame_tick && (state_q == S_PLAY);
        hold_d    = !((state_d == S_PLAY) || (state_d == S_PAUSE));
        over_d    = (state_d == S_OVER);
    end

    assign phys_en   = phys_en_q;
    assign ball_hold = hold_q;
    assign serve_dir = dir_q;
    assign score     = {opp_q, ply_q};
    assign state     = state_q;
    assign game_over = over_q;
    assign winner    = winner_q;

endmodule
